// File: rtl/kp_pkg.sv
// Shared types and the key map for the 4x4 hex keypad scanner.
//   kp_state_e  : press/release FSM states
//   scan_res_e  : classification of one full four-row scan
//   key_map()   : (row index, column index) -> hex code
package kp_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned ENTRY_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_res_e;

    // Keypad legend: '*' reads as E and '#' as F.
    function automatic logic [CODE_W-1:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [CODE_W-1:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
//   clk_i  : sampling clock
//   rst_ni : synchronous active-low reset (clears both stages)
//   d_i    : asynchronous input
//   q_o    : synchronized output
module kp_sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: strobes rows, classifies each full scan, debounces
// press and release, and shifts accepted codes into a 32-bit entry register.
//   CLK100MHZ : system clock
//   reset     : synchronous active-low reset
//   col       : active-low column inputs (asynchronous)
//   clear     : zeroes entry on the next edge (wins over a same-cycle accept)
//   row       : one-hot active-low row drive
//   key_valid : one-cycle pulse per accepted press
//   key_code  : last accepted code
//   key_held  : high while the accepted key is considered held
//   entry     : last eight codes, newest in [3:0]
module keypad_scanner
    import kp_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    input  logic [COLS-1:0]     col,
    input  logic                clear,
    output logic [ROWS-1:0]     row,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_held,
    output logic [ENTRY_W-1:0]  entry
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DS_C     = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    // ---------------- column synchronizer ----------------
    logic [COLS-1:0] col_s;

    kp_sync2 #(.WIDTH(COLS)) u_sync (
        .clk_i  (CLK100MHZ),
        .rst_ni (reset),
        .d_i    (col),
        .q_o    (col_s)
    );

    // ---------------- row stepping and scan accumulation ----------------
    logic [DIV_W-1:0]  div_q;
    logic [1:0]        idx_q;
    logic [ROWS-1:0]   row_q;
    logic [1:0]        acc_cnt_q;   // low bits seen so far this scan, saturating at 2
    logic [CODE_W-1:0] acc_code_q;

    logic              sample_c;
    logic              scan_end_c;
    logic [2:0]        row_cnt_c;
    logic [CODE_W-1:0] row_code_c;
    logic [3:0]        tot_c;
    logic [1:0]        tot_sat_c;
    logic [CODE_W-1:0] code_now_c;
    scan_res_e         res_c;

    assign sample_c   = (div_q == DIV_LAST);
    assign scan_end_c = sample_c && (idx_q == 2'd3);

    // Classify the current row's columns and fold them into the running scan.
    always_comb begin
        row_cnt_c  = 3'd0;
        row_code_c = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            if (!col_s[c]) begin
                row_cnt_c  = row_cnt_c + 3'd1;
                row_code_c = key_map(idx_q, 2'(c));
            end
        end
        tot_c      = 4'(acc_cnt_q) + 4'(row_cnt_c);
        tot_sat_c  = (tot_c >= 4'd2) ? 2'd2 : tot_c[1:0];
        // Only meaningful when the scan total is exactly one.
        code_now_c = (acc_cnt_q != 2'd0) ? acc_code_q : row_code_c;
        if (tot_c == 4'd0) begin
            res_c = NONE;
        end else if (tot_c == 4'd1) begin
            res_c = SINGLE;
        end else begin
            res_c = MULTI;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            div_q      <= '0;
            idx_q      <= 2'd0;
            row_q      <= 4'b1110;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
        end else begin
            if (sample_c) begin
                div_q <= '0;
                idx_q <= idx_q + 2'd1;
                row_q <= {row_q[ROWS-2:0], row_q[ROWS-1]};
                if (scan_end_c) begin
                    acc_cnt_q  <= 2'd0;
                    acc_code_q <= '0;
                end else begin
                    acc_cnt_q  <= tot_sat_c;
                    acc_code_q <= code_now_c;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // ---------------- press/release FSM ----------------
    kp_state_e         state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the FSM only moves on the scan-result event.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (scan_end_c) begin
            case (state_q)
                IDLE: begin
                    if (res_c == SINGLE) begin
                        cand_d  = code_now_c;
                        cnt_d   = ONE_C;
                        state_d = (ONE_C >= DS_C) ? PRESSED : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (res_c == SINGLE && code_now_c == cand_q) begin
                        cnt_d   = cnt_q + ONE_C;
                        state_d = ((cnt_q + ONE_C) >= DS_C) ? PRESSED : DEBOUNCE;
                    end else if (res_c == SINGLE) begin
                        cand_d  = code_now_c;
                        cnt_d   = ONE_C;
                        state_d = (ONE_C >= DS_C) ? PRESSED : DEBOUNCE;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (res_c == NONE) begin
                        cnt_d   = ONE_C;
                        state_d = (ONE_C >= DS_C) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (res_c == NONE) begin
                        cnt_d   = cnt_q + ONE_C;
                        state_d = ((cnt_q + ONE_C) >= DS_C) ? IDLE : RELEASE;
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    logic               key_valid_q, key_valid_d;
    logic [CODE_W-1:0]  key_code_q, key_code_d;
    logic               key_held_q, key_held_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic               accept_c;

    // A press is accepted exactly on the transition into PRESSED from the
    // pre-press states; RELEASE->PRESSED is a bounce, not a new key.
    always_comb begin
        accept_c    = (state_d == PRESSED) && (state_q == IDLE || state_q == DEBOUNCE);
        key_valid_d = accept_c;
        key_code_d  = accept_c ? cand_d : key_code_q;
        key_held_d  = (state_d == PRESSED) || (state_d == RELEASE);
        entry_d     = entry_q;
        if (clear) begin
            entry_d = '0;
        end else if (accept_c) begin
            entry_d = {entry_q[ENTRY_W-CODE_W-1:0], cand_d};
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            entry_q     <= '0;
        end else begin
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            entry_q     <= entry_d;
        end
    end

    assign row       = row_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign entry     = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a directed table of scans with
// hand-derived expectations, a few corner sequences, and a randomized run
// compared cycle by cycle against a scan-level reference model.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DS       = 2;

    logic        CLK100MHZ = 1'b0;
    logic        reset;
    logic [3:0]  col;
    logic        clear;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [31:0] entry;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .col       (col),
        .clear     (clear),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .entry     (entry)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Keypad model: bit r*4+c of pressed shorts row r to column c.
    logic [15:0] pressed = 16'h0;
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (row[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) col[c] = 1'b0;
    end

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one step per full scan) ----------------
    bit          m_held;
    int          m_run;
    logic [3:0]  m_run_key;
    int          m_none_run;
    logic [3:0]  m_code;
    logic [31:0] m_entry;
    bit          m_valid_now;

    task automatic model_reset();
        m_held = 0; m_run = 0; m_run_key = 4'h0; m_none_run = 0;
        m_code = 4'h0; m_entry = 32'h0; m_valid_now = 0;
    endtask

    function automatic logic [3:0] key_of(input logic [15:0] mask);
        logic [3:0] k;
        k = 4'h0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = kmap[i];
        return k;
    endfunction

    // Press needs DS consecutive identical single-key scans; release needs DS
    // consecutive empty scans. Returns whether a press is accepted.
    task automatic model_scan(input logic [15:0] mask, output bit fire, output logic [3:0] fcode);
        int n;
        logic [3:0] k;
        n = $countones(mask);
        fire = 0;
        fcode = 4'h0;
        if (!m_held) begin
            if (n == 1) begin
                k = key_of(mask);
                if (m_run > 0 && k == m_run_key) m_run++;
                else begin m_run = 1; m_run_key = k; end
                if (m_run >= int'(DS)) begin
                    fire = 1; fcode = k; m_held = 1; m_none_run = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_none_run++;
                if (m_none_run >= int'(DS)) begin m_held = 0; m_run = 0; end
            end else begin
                m_none_run = 0;
            end
        end
    endtask

    // Run one full scan (16 cycles) from cycle 0, checking every cycle.
    task automatic do_scan(input logic [15:0] mask, input int clr_cyc, input bit rnd_clr);
        bit fire;
        logic [3:0] fcode;
        logic [3:0] exp_row;
        pressed = mask;
        for (int c = 0; c < 16; c++) begin
            exp_row = ~(4'b0001 << (c / 4));
            chk("row", 32'(row), 32'(exp_row));
            chk("key_valid", 32'(key_valid), 32'(m_valid_now));
            chk("key_held", 32'(key_held), 32'(m_held));
            chk("key_code", 32'(key_code), 32'(m_code));
            chk("entry", entry, m_entry);
            clear = (c == clr_cyc) || (rnd_clr && $urandom_range(0, 31) == 0);
            fire = 0;
            fcode = 4'h0;
            if (c == 15) model_scan(mask, fire, fcode);
            if (clear) m_entry = 32'h0;
            else if (fire) m_entry = {m_entry[27:0], fcode};
            if (fire) m_code = fcode;
            m_valid_now = fire;
            @(posedge CLK100MHZ); #1;
            clear = 1'b0;
        end
    endtask

    task automatic apply_reset();
        pressed = 16'h0;
        reset = 1'b0;
        repeat (3) begin @(posedge CLK100MHZ); #1; end
        chk("rst_row", 32'(row), 32'h0000000E);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_key_code", 32'(key_code), 32'h0);
        chk("rst_key_held", 32'(key_held), 32'h0);
        chk("rst_entry", entry, 32'h0);
        model_reset();
        reset = 1'b1;   // the edge just taken had reset low: scan cycle 0 starts now
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [15:0] mask;
        int          clr;
        logic        v;
        logic        h;
        logic [3:0]  code;
        logic [31:0] ent;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] m, input int clr, input logic v,
                                input logic h, input logic [3:0] code, input logic [31:0] ent);
        vec_t t;
        t.mask = m; t.clr = clr; t.v = v; t.h = h; t.code = code; t.ent = ent;
        return t;
    endfunction

    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0400;
    localparam logic [15:0] K12 = 16'h0003;
    localparam logic [15:0] KF  = 16'h4000;
    localparam logic [15:0] K3  = 16'h0004;
    localparam logic [15:0] K5  = 16'h0020;

    vec_t tbl[$];
    int   seq_bits [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 3};   // keys 1..8 then A

    initial begin
        reset = 1'b0;
        clear = 1'b0;

        // Expectations observed in cycle 0 after each scan completes.
        tbl.push_back(mk(16'h0, -1, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(16'h0, -1, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(K6,    -1, 0, 0, 4'h0, 32'h0));
        tbl.push_back(mk(K6,    -1, 1, 1, 4'h6, 32'h6));
        tbl.push_back(mk(K6,    -1, 0, 1, 4'h6, 32'h6));
        tbl.push_back(mk(K6,    -1, 0, 1, 4'h6, 32'h6));
        tbl.push_back(mk(K6,    -1, 0, 1, 4'h6, 32'h6));
        tbl.push_back(mk(16'h0, -1, 0, 1, 4'h6, 32'h6));
        tbl.push_back(mk(16'h0, -1, 0, 0, 4'h6, 32'h6));
        tbl.push_back(mk(16'h0,  5, 0, 0, 4'h6, 32'h0));
        tbl.push_back(mk(K6,    -1, 0, 0, 4'h6, 32'h0));
        tbl.push_back(mk(16'h0, -1, 0, 0, 4'h6, 32'h0));
        tbl.push_back(mk(K9,    -1, 0, 0, 4'h6, 32'h0));
        tbl.push_back(mk(K9,    -1, 1, 1, 4'h9, 32'h9));
        tbl.push_back(mk(K9,    -1, 0, 1, 4'h9, 32'h9));
        tbl.push_back(mk(16'h0, -1, 0, 1, 4'h9, 32'h9));
        tbl.push_back(mk(16'h0, -1, 0, 0, 4'h9, 32'h9));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(K12, -1, 0, 0, 4'h9, 32'h9));

        apply_reset();

        foreach (tbl[i]) begin
            do_scan(tbl[i].mask, tbl[i].clr, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 32'(key_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_held", i), 32'(key_held), 32'(tbl[i].h));
            chk($sformatf("tbl%0d_code", i), 32'(key_code), 32'(tbl[i].code));
            chk($sformatf("tbl%0d_entry", i), entry, tbl[i].ent);
        end

        // Nine entries overflow the oldest nibble.
        do_scan(16'h0, 3, 1'b0);
        for (int i = 0; i < 9; i++) begin
            do_scan(16'(1) << seq_bits[i], -1, 1'b0);
            do_scan(16'(1) << seq_bits[i], -1, 1'b0);
            do_scan(16'h0, -1, 1'b0);
            do_scan(16'h0, -1, 1'b0);
        end
        chk("seq_entry", entry, 32'h2345678A);
        chk("seq_code", 32'(key_code), 32'hA);

        // Clear during the key_valid cycle of F.
        do_scan(KF, -1, 1'b0);
        do_scan(KF, -1, 1'b0);
        chk("f_valid", 32'(key_valid), 32'h1);
        do_scan(16'h0, 0, 1'b0);
        chk("f_entry", entry, 32'h0);
        chk("f_code", 32'(key_code), 32'hF);
        do_scan(16'h0, -1, 1'b0);

        // Clear in the same cycle as the accept: clear wins, pulse still fires.
        do_scan(K3, -1, 1'b0);
        do_scan(K3, 15, 1'b0);
        chk("k3_valid", 32'(key_valid), 32'h1);
        chk("k3_code", 32'(key_code), 32'h3);
        chk("k3_entry", entry, 32'h0);
        do_scan(16'h0, -1, 1'b0);
        do_scan(16'h0, -1, 1'b0);

        // Reset mid-debounce discards the pending press.
        do_scan(K5, -1, 1'b0);
        pressed = K5;
        repeat (6) begin @(posedge CLK100MHZ); #1; end
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_scan(16'h0, -1, 1'b0);
            chk("postrst_valid", 32'(key_valid), 32'h0);
            chk("postrst_held", 32'(key_held), 32'h0);
        end

        // Randomized scans against the reference model.
        for (int s = 0; s < 160; s++) begin
            logic [15:0] m;
            int kind, a, b, reps;
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                m = 16'h0;
            end else if (kind < 8) begin
                m = 16'(1) << $urandom_range(0, 15);
            end else begin
                a = int'($urandom_range(0, 15));
                b = (a + int'($urandom_range(1, 15))) % 16;
                m = (16'(1) << a) | (16'(1) << b);
            end
            reps = int'($urandom_range(1, 3));
            for (int r = 0; r < reps; r++) do_scan(m, -1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the board's multiplexed 7-segment display driver.
- The display driver steps a one-hot active-low digit strobe and drives segments out. This block steps a one-hot active-low row strobe across a 4x4 hex keypad and reads the columns in.
- It debounces presses, emits one hex code per press, and shifts the codes into a 32-bit entry register. That register is sized so the display's data word can show it.
- Sits at board top next to the clock divider and display logic, on CLK100MHZ.

Parameters:
- SCAN_DIV, 100000: CLK100MHZ cycles each row is driven (1 kHz row rate). Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release. Range 1..15.

Ports:
- CLK100MHZ  input  1  system clock; the block's only clock.
- reset  input  1  synchronous, active-low reset.
- col  input  4  keypad columns; active-low, externally pulled up; asynchronous to the clock.
- clear  input  1  synchronous; zeroes entry.
- row  output  4  row drive; exactly one bit low at any time.
- key_valid  output  1  one-cycle pulse per accepted press.
- key_code  output  4  code of the last accepted key; held between presses.
- key_held  output  1  high while the accepted key is held (PRESSED/RELEASE states).
- entry  output  32  last 8 codes entered; newest code in [3:0].

Behaviour:
- Reset (reset==0 at a clock edge) values:
  - row=4'b1110; key_valid=0; key_code=0; key_held=0; entry=0.
  - Scan counter, row index, debounce count and synchronizer all cleared; FSM=IDLE.
  - Reset mid-press discards the press: no key_valid is emitted for it.
- Synchronizer: col passes through two flops before any use.
- Row stepping:
  - A divider counts 0..SCAN_DIV-1. On the wrap, the row index advances 0->1->2->3->0.
  - row = ~(4'b0001 << index).
- Column sampling: the synchronized col is sampled on the last divider cycle of each row (count==SCAN_DIV-1). This gives >= 2 cycles of settling after the row change.
- Scan result: built over one full scan (rows 0..3). Evaluated on the last cycle of row 3. Three outcomes:
  - NONE: no bit low in any row.
  - SINGLE(code): exactly one low bit across all 16 positions.
  - MULTI: two or more low bits; treated as invalid.
- Key map, row r / col c -> code (c0..c3 within each row):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- FSM, advanced only at scan-result events:
  - IDLE: SINGLE(k) -> DEBOUNCE with cand=k, cnt=1. NONE or MULTI -> stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS, go to PRESSED. In the following clock cycle: key_valid=1, key_code=cand, entry={entry[27:0],cand}.
    - SINGLE(other) -> restart with cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
    - With DEBOUNCE_SCANS=1, the first SINGLE goes directly to PRESSED.
  - PRESSED: NONE -> RELEASE with cnt=1. SINGLE (any key) or MULTI -> stay; no new code is emitted.
  - RELEASE:
    - NONE -> cnt+1; when cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - Any non-NONE result -> PRESSED.
    - With DEBOUNCE_SCANS=1, the first NONE goes directly to IDLE.
- key_held is high in PRESSED and RELEASE.
- Latency: the fastest accept is the cycle after the scan that completes DEBOUNCE_SCANS matching scans.
- clear:
  - Sets entry=0 on the next edge.
  - If key_valid fires in the same cycle, clear wins: entry=0. key_valid and key_code still update.
- Entry overflow: the oldest nibble [31:28] is shifted out and discarded.

Decomposition:
- Package kp_pkg holds:
  - FSM state enum: IDLE, DEBOUNCE, PRESSED, RELEASE.
  - Scan-result encoding: NONE, SINGLE, MULTI.
  - Key-map function (row,col)->code.
- One sub-module, kp_sync2: a 4-bit two-flop synchronizer.
- Everything else stays in keypad_scanner.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2; one full scan = 16 cycles.
1. Release reset, no key pressed -> row cycles 1110, 1101, 1011, 0111, each for 4 cycles. key_valid never asserts. entry=0.
2. Hold r1/c2 (key 6) for 5 scans, then release -> exactly one key_valid pulse, at the cycle after the 2nd scan end. key_code=6, entry=0x00000006. key_held falls 2 scans after release.
3. Hold key 6 for 1 scan, release for 1 scan, then press key 9 for 3 scans -> no pulse for 6. One pulse for 9. entry=0x00000009.
4. Press key 1 and key 2 together for 4 scans -> no key_valid; FSM stays in IDLE.
5. Enter 1,2,3,4,5,6,7,8,A in sequence -> entry=0x2345678A after the 9th entry.
6. Assert clear in the key_valid cycle of key F -> entry=0, key_code=F. Separately, pull reset low mid-DEBOUNCE -> all outputs return to reset values and no pulse follows.
